multu_hilo_sequencer: RTL and testbench

- Controller for the pipeline's multi-cycle unsigned multiplier and Hi/Lo register pair.
- Issues the multiplier start pulse when a MULTU reaches EX and counts the multiplier latency.
- Generates the single-cycle Hi/Lo write enable at the end of the operation.
- Stalls the front of the pipeline when an MFHI, MFLO or second MULTU reaches EX before the result is committed. Drives the EX result-select (ALU/Hi/Lo) for the EX/MEM mux.

---
 rtl/multu_hilo_sequencer.sv | 74 +++++++
 tb/tb_multu_hilo_sequencer.sv | 95 +++++++++
 2 files changed

// File: rtl/multu_hilo_sequencer.sv
// multu_hilo_sequencer: MULTU issue/latency controller and Hi/Lo write, stall and EX result-select generator
// ports: clk/rst (sync, active-high); ex_valid/ex_multu/ex_mfhi/ex_mflo describe the EX instruction;
// mul_start, hilo_we one-cycle pulses; mul_busy op in flight; stall freezes the pipeline front;
// hilo_sel EX select (00 ALU, 01 Hi, 10 Lo); hilo_valid Hi/Lo hold a product; stall_cycles saturating stall count
module multu_hilo_sequencer #(
  parameter int MUL_LAT     = 32,
  parameter int CNT_W       = 6,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid,
  input  logic                   ex_multu,
  input  logic                   ex_mfhi,
  input  logic                   ex_mflo,
  output logic                   mul_start,
  output logic                   hilo_we,
  output logic                   mul_busy,
  output logic                   stall,
  output logic [1:0]             hilo_sel,
  output logic                   hilo_valid,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  typedef enum logic [1:0] {IDLE, BUSY, WRITE} state_e;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   hilo_valid_q, hilo_valid_d;
  logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic                   busy_c, stall_c, start_c;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      count_q        <= '0;
      hilo_valid_q   <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      hilo_valid_q   <= hilo_valid_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    hilo_valid_d   = hilo_valid_q;
    stall_cycles_d = (stall_c && !(&stall_cycles_q)) ? stall_cycles_q + 1'b1 : stall_cycles_q;
    case (state_q)
      IDLE: if (start_c) begin
        state_d = BUSY;
        count_d = CNT_W'(MUL_LAT - 1);
      end
      BUSY: if (count_q == '0) state_d = WRITE;
            else count_d = count_q - 1'b1;
      WRITE: begin
        state_d      = IDLE;
        hilo_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy_c       = ~rst & (state_q != IDLE);
    stall_c      = busy_c & ex_valid & (ex_mfhi | ex_mflo | ex_multu);
    start_c      = ~rst & ~busy_c & ex_valid & ex_multu;
    mul_start    = start_c;
    mul_busy     = busy_c;
    stall        = stall_c;
    hilo_we      = ~rst & (state_q == WRITE);
    hilo_sel     = (~rst & ex_valid & ~stall_c) ? (ex_mfhi ? 2'b01 : ex_mflo ? 2'b10 : 2'b00) : 2'b00;
    hilo_valid   = hilo_valid_q;
    stall_cycles = stall_cycles_q;
  end
endmodule

// File: tb/tb_multu_hilo_sequencer.sv
// tb_multu_hilo_sequencer: directed plus random checks against a timeline model of MULTU operations
module tb_multu_hilo_sequencer;
  localparam int L  = 4;
  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;
  logic clk = 1'b0;
  logic rst, ex_valid, ex_multu, ex_mfhi, ex_mflo;
  logic mul_start, hilo_we, mul_busy, stall, hilo_valid;
  logic [1:0] hilo_sel;
  logic [SW-1:0] stall_cycles;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int op_end = -1;
  bit hv = 1'b0;
  int sc = 0;
  always #5 clk = ~clk;
  multu_hilo_sequencer #(.MUL_LAT(L), .CNT_W(3), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_multu(ex_multu), .ex_mfhi(ex_mfhi),
    .ex_mflo(ex_mflo), .mul_start(mul_start), .hilo_we(hilo_we), .mul_busy(mul_busy),
    .stall(stall), .hilo_sel(hilo_sel), .hilo_valid(hilo_valid), .stall_cycles(stall_cycles)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic step(input bit r, input bit v, input bit m, input bit h, input bit l);
    bit idle, e_start, e_stall, e_we, e_busy;
    logic [1:0] e_sel;
    rst = r; ex_valid = v; ex_multu = m; ex_mfhi = h; ex_mflo = l;
    @(negedge clk);
    idle    = (cyc > op_end);
    e_busy  = !r && !idle;
    e_start = !r && v && m && idle;
    e_stall = !r && v && (m || h || l) && !idle;
    e_we    = !r && (cyc == op_end);
    e_sel   = (!r && v && !e_stall) ? (h ? 2'b01 : l ? 2'b10 : 2'b00) : 2'b00;
    chk("mul_start", 32'(mul_start), 32'(e_start));
    chk("hilo_we", 32'(hilo_we), 32'(e_we));
    chk("mul_busy", 32'(mul_busy), 32'(e_busy));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("hilo_sel", 32'(hilo_sel), 32'(e_sel));
    if (!r) begin
      chk("hilo_valid", 32'(hilo_valid), 32'(hv));
      chk("stall_cycles", 32'(stall_cycles), 32'(sc));
    end
    @(posedge clk);
    if (r) begin
      op_end = -1; hv = 1'b0; sc = 0;
    end else begin
      if (cyc == op_end) hv = 1'b1;
      if (e_stall && sc < SMAX) sc++;
      if (e_start) op_end = cyc + L + 1;
    end
    cyc++;
    #1;
  endtask
  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    repeat (7) step(0, 1, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    repeat (6) step(0, 1, 1, 0, 0);
    repeat (7) step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (8) step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 1, 1);
    repeat (4) begin
      step(0, 1, 1, 0, 0);
      repeat (6) step(0, 1, 0, 1, 0);
    end
    repeat (3) step(0, 1, 0, 0, 0);
    repeat (600) begin
      int k;
      k = $urandom_range(0, 7);
      step($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
           k == 0 || k == 7, k == 1 || k == 3 || k == 7, k == 2 || k == 3);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
